// File: rtl/board_ram_pkg.sv
// Shared defaults and cell codes for the snake-game board memory.
package board_ram_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [3:0] {
        CELL_EMPTY = 4'd0,
        CELL_BODY  = 4'd1,
        CELL_HEAD  = 4'd2,
        CELL_FOOD  = 4'd3
    } cell_e;

endpackage

// File: rtl/board_ram_if.sv
// Bus bundle between the game logic / display scanner and board_ram.
interface board_ram_if
    import board_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              clr_i;
    logic              busy_o;
    logic              a_wr_en_i;
    logic              a_rd_en_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_wr_data_i;
    logic [DATA_W-1:0] a_rd_data_o;
    logic              a_rd_valid_o;
    logic              b_rd_en_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_rd_data_o;

    modport master (
        output clr_i, a_wr_en_i, a_rd_en_i, a_addr_i, a_wr_data_i, b_rd_en_i, b_addr_i,
        input  busy_o, a_rd_data_o, a_rd_valid_o, b_rd_data_o
    );

    modport slave (
        input  clr_i, a_wr_en_i, a_rd_en_i, a_addr_i, a_wr_data_i, b_rd_en_i, b_addr_i,
        output busy_o, a_rd_data_o, a_rd_valid_o, b_rd_data_o
    );

endinterface

// File: rtl/board_ram_clear_fsm.sv
// Sequential clear engine: sweeps every cell once after reset or on request.
//  state    | meaning
//  ST_CLEAR | writing the clear value to cell cnt, port A locked out
//  ST_IDLE  | normal operation, waiting for a clear request
module board_ram_clear_fsm #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_i) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    if (clr_i) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy_o     = (state == ST_CLEAR);
    assign clr_we_o   = (state == ST_CLEAR);
    assign clr_addr_o = cnt;

endmodule

// File: rtl/board_ram.sv
// Dual-port board store: port A read/write for game logic, port B read-only
// for the renderer, with a sequential clear engine sharing the write port.
module board_ram
    import board_ram_pkg::*;
#(
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter int              DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(CELL_EMPTY)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    board_ram_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    board_ram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (bus.clr_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    logic              a_ok;
    logic              a_in_range;
    logic              b_in_range;
    logic              a_we;
    logic              a_re;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;

    // A clear request in IDLE outranks a same-cycle port A access.
    assign a_ok       = !busy && !bus.clr_i;
    assign a_in_range = ({1'b0, bus.a_addr_i} < DEPTH_L);
    assign b_in_range = ({1'b0, bus.b_addr_i} < DEPTH_L);
    assign a_we       = a_ok && bus.a_wr_en_i && a_in_range;
    assign a_re       = a_ok && bus.a_rd_en_i;

    assign p0_we   = clr_we || a_we;
    assign p0_addr = clr_we ? clr_addr  : bus.a_addr_i;
    assign p0_data = clr_we ? CLEAR_VAL : bus.a_wr_data_i;

    always_ff @(posedge clk_i) begin
        if (p0_we) begin
            mem[p0_addr] <= p0_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.a_rd_data_o  <= '0;
            bus.a_rd_valid_o <= 1'b0;
        end else begin
            bus.a_rd_valid_o <= a_re;
            if (a_re) begin
                bus.a_rd_data_o <= a_in_range ? mem[bus.a_addr_i] : CLEAR_VAL;
            end
        end
    end

    // Renderer sees an empty board for the whole sweep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.b_rd_data_o <= CLEAR_VAL;
        end else if (busy) begin
            bus.b_rd_data_o <= CLEAR_VAL;
        end else if (bus.b_rd_en_i) begin
            bus.b_rd_data_o <= b_in_range ? mem[bus.b_addr_i] : CLEAR_VAL;
        end
    end

    assign bus.busy_o = busy;

endmodule

// File: doc/board_ram.md
# board_ram

Parametrised dual-port board memory for the snake game. It replaces the single-port bidirectional 4-bit × 256 store with separate read/write buses and two ports: port A is read/write for game logic, port B is read-only for the VGA renderer. It adds a sequential hardware clear engine so that reset or a game restart wipes the board over DEPTH cycles instead of in a single huge reset fan-out. It sits between the game FSM (port A) and the display scanner (port B).

## Interface
- DATA_W, 4, cell width in bits (cell code: empty/body/head/food…)
- ADDR_W, 8, address width
- DEPTH, 2**ADDR_W, number of cells; must be ≤ 2**ADDR_W
- CLEAR_VAL, 0, value written by the clear engine
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clr_i  in  1  single-cycle request to start a clear sweep
- busy_o  out  1  clear sweep in progress; port A ignored while high
- a_wr_en_i  in  1  port A write strobe
- a_rd_en_i  in  1  port A read strobe
- a_addr_i  in  ADDR_W  port A address
- a_wr_data_i  in  DATA_W  port A write data
- a_rd_data_o  out  DATA_W  port A read data, registered
- a_rd_valid_o  out  1  a_rd_data_o valid this cycle
- b_rd_en_i  in  1  port B read strobe
- b_addr_i  in  ADDR_W  port B address
- b_rd_data_o  out  DATA_W  port B read data, registered

## Operation
- Reset affects control state only, not the array. Reset values: busy_o=1, a_rd_data_o=0, a_rd_valid_o=0, b_rd_data_o=CLEAR_VAL, clear counter=0, FSM=CLEAR.
- FSM has two states:
  - CLEAR: each cycle writes CLEAR_VAL to address cnt, then increments cnt. When cnt==DEPTH-1 the write is performed and the FSM moves to IDLE. busy_o=1.
  - IDLE: busy_o=0. clr_i=1 → go to CLEAR with cnt=0.
- clr_i while in CLEAR restarts the sweep: cnt=0, remain in CLEAR.
- Port A in IDLE:
  - Write: mem[a_addr_i] ← a_wr_data_i.
  - Read: a_rd_data_o ← mem[a_addr_i], a_rd_valid_o=1 on the next cycle, otherwise 0.
  - Write and read together on the same address are read-first: the read returns the old data.
- Port A in CLEAR, or when clr_i is sampled in IDLE: writes and reads are dropped and a_rd_valid_o stays 0. clr_i has priority over a simultaneous write.
- Port B:
  - Read with b_rd_en_i=1: b_rd_data_o ← mem[b_addr_i] next cycle; it holds its value when b_rd_en_i=0.
  - While busy_o=1, b_rd_data_o ← CLEAR_VAL regardless of address, so the display shows an empty board.
  - A port B read of an address port A writes in the same cycle returns the old data.
- Addresses ≥ DEPTH are out of range: writes are ignored, reads return CLEAR_VAL.

## Timing
- Read latency is 1 cycle on both ports. No backpressure exists.
- After rst_i deasserts, clear writes occur on edges 1..DEPTH and busy_o falls after edge DEPTH. The first port A access is accepted on edge DEPTH+1.
- clr_i sampled on edge n → busy_o=1 after edge n; the sweep occupies edges n+1..n+DEPTH.
- Reset asserted mid-sweep or mid-read: outputs take reset values immediately, and the sweep restarts from 0 after release.

## Structure
- Package board_ram_pkg holds the default DATA_W/ADDR_W and the cell codes CELL_EMPTY=0, CELL_BODY=1, CELL_HEAD=2, CELL_FOOD=3.
- One sub-module, board_ram_clear_fsm, contains the state, the counter and busy_o, and produces the clear write enable/address. The top level holds the array, the port muxing and the output registers.
- The array is inferred as block RAM: two ports, port 0 write-muxed between clear and A, port 1 read-only for B.

## Test plan
- Reset release with DEPTH=256: busy_o high for exactly 256 edges. Afterwards, reading every address on both ports returns 0.
- Write A addr 0x12 = 0x7, then read A 0x12 on the next cycle → a_rd_data_o=0x7 with a_rd_valid_o=1 one cycle later. Read B 0x12 → 0x7.
- Same-cycle A write 0x5 and A read of the same address holding 0x3 → returns 0x3. A following read returns 0x5.
- clr_i pulse while writing 0x9 to 0x40 → write dropped, busy_o high for 256 cycles, B reads 0 throughout, and 0x40 reads 0 afterwards.
- clr_i again at cycle 100 of a sweep → busy_o stays high for 256 further edges.
- rst_i pulse at cycle 50 of a sweep, with memory previously filled with 0xF → all outputs at reset values, then a full 256-cycle sweep, after which every cell reads 0.
